// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings, parity modes and frame-format helpers
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } uart_state_t;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;
   localparam logic [1:0] PAR_MARK = 2'b11;

   localparam logic [3:0] DATA_BITS_MIN = 4'd5;
   localparam logic [3:0] DATA_BITS_MAX = 4'd9;

   function automatic logic [3:0] clamp_data_bits(input logic [3:0] n);
      if (n < DATA_BITS_MIN) return DATA_BITS_MIN;
      if (n > DATA_BITS_MAX) return DATA_BITS_MAX;
      return n;
   endfunction

   // Keeps only the low n bits of a 9-bit word; n must already be clamped.
   function automatic logic [8:0] data_mask(input logic [3:0] n);
      return 9'h1FF >> (DATA_BITS_MAX - n);
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO with occupancy level, shared by the UART TX and RX engines
module uart_sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic                     i_Clock,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // Storage is deliberately unreset; only the pointers define validity.
   always_ff @(posedge i_Clock) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge i_Clock or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - buffered UART transmitter with runtime frame format and divisor shadow
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_W      = 32
) (
   input  logic                          i_Clock,
   input  logic                          rst_n,
   input  logic [DIV_W-1:0]              CLKS_PER_BIT,
   input  logic                          ld_CLKS_PER_BIT,
   input  logic [3:0]                    i_Cfg_Data_Bits,
   input  logic [1:0]                    i_Cfg_Parity,
   input  logic                          i_Cfg_Stop2,
   input  logic                          i_Tx_Valid,
   input  logic [8:0]                    i_Tx_Data,
   output logic                          o_Tx_Ready,
   output logic                          o_Tx_Serial,
   output logic                          o_Tx_Active,
   output logic                          o_Tx_Done,
   output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Level
);

   uart_state_t      state, state_nxt;
   logic [DIV_W-1:0] div_shadow, div_lat, tick, tick_nxt;
   logic [3:0]       idx, idx_nxt, nbits_lat, nbits_cfg;
   logic [1:0]       par_lat;
   logic             stop2_lat;
   logic [8:0]       data_lat, fifo_data;
   logic             fifo_pop, fifo_full, fifo_empty;
   logic             bit_end, last_data, last_stop;
   logic             par_bit, line_nxt, done_nxt;

   assign o_Tx_Ready  = !fifo_full;
   assign o_Tx_Active = (state != S_IDLE);
   assign nbits_cfg   = clamp_data_bits(i_Cfg_Data_Bits);
   assign bit_end     = (tick == div_lat - DIV_W'(1));
   assign last_data   = (idx == nbits_lat - 4'd1);
   assign last_stop   = (idx == {3'b000, stop2_lat});

   uart_sync_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
      .i_Clock (i_Clock),
      .rst_n   (rst_n),
      .push    (i_Tx_Valid),
      .wr_data (i_Tx_Data),
      .pop     (fifo_pop),
      .rd_data (fifo_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (o_Fifo_Level)
   );

   always_ff @(posedge i_Clock or negedge rst_n) begin
      if (!rst_n) div_shadow <= '0;
      else if (ld_CLKS_PER_BIT) div_shadow <= CLKS_PER_BIT;
   end

   always_ff @(posedge i_Clock or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         tick        <= '0;
         idx         <= '0;
         o_Tx_Serial <= 1'b1;
         o_Tx_Done   <= 1'b0;
         div_lat     <= DIV_W'(1);
         nbits_lat   <= DATA_BITS_MIN;
         par_lat     <= PAR_NONE;
         stop2_lat   <= 1'b0;
         data_lat    <= '0;
      end else begin
         state       <= state_nxt;
         tick        <= tick_nxt;
         idx         <= idx_nxt;
         o_Tx_Serial <= line_nxt;
         o_Tx_Done   <= done_nxt;
         // Whole frame format is frozen at pop so register writes mid-frame cannot tear it.
         if (fifo_pop) begin
            data_lat  <= fifo_data & data_mask(nbits_cfg);
            nbits_lat <= nbits_cfg;
            par_lat   <= i_Cfg_Parity;
            stop2_lat <= i_Cfg_Stop2;
            div_lat   <= (div_shadow == '0) ? DIV_W'(1) : div_shadow;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      tick_nxt  = tick + DIV_W'(1);
      idx_nxt   = idx;
      fifo_pop  = 1'b0;
      done_nxt  = 1'b0;
      if (state != S_IDLE && bit_end) tick_nxt = '0;
      case (state)
         S_IDLE: begin
            tick_nxt = '0;
            idx_nxt  = '0;
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               state_nxt = S_START;
            end
         end
         S_START: if (bit_end) state_nxt = S_DATA;
         S_DATA: if (bit_end) begin
            if (last_data) begin
               idx_nxt   = '0;
               state_nxt = (par_lat == PAR_NONE) ? S_STOP : S_PARITY;
            end else begin
               idx_nxt = idx + 4'd1;
            end
         end
         S_PARITY: if (bit_end) state_nxt = S_STOP;
         S_STOP: if (bit_end) begin
            if (last_stop) begin
               idx_nxt   = '0;
               state_nxt = S_IDLE;
               done_nxt  = 1'b1;
            end else begin
               idx_nxt = idx + 4'd1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Line value is computed for the upcoming state so the registered pin lines up with it.
   always_comb begin
      par_bit = 1'b1;
      case (par_lat)
         PAR_EVEN: par_bit = ^data_lat;
         PAR_ODD:  par_bit = ~^data_lat;
         default:  par_bit = 1'b1;
      endcase
      line_nxt = 1'b1;
      case (state_nxt)
         S_START:  line_nxt = 1'b0;
         S_DATA:   line_nxt = data_lat[idx_nxt];
         S_PARITY: line_nxt = par_bit;
         default:  line_nxt = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - self-checking bench for uart_tx_cfg against a per-cycle line model
module tb_uart_tx_cfg;

   localparam int DEPTH = 4;
   localparam int DIV_W = 32;

   logic             i_Clock = 1'b0;
   logic             rst_n = 1'b0;
   logic [DIV_W-1:0] CLKS_PER_BIT = '0;
   logic             ld_CLKS_PER_BIT = 1'b0;
   logic [3:0]       i_Cfg_Data_Bits = 4'd8;
   logic [1:0]       i_Cfg_Parity = 2'b00;
   logic             i_Cfg_Stop2 = 1'b0;
   logic             i_Tx_Valid = 1'b0;
   logic [8:0]       i_Tx_Data = '0;
   logic             o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done;
   logic [2:0]       o_Fifo_Level;

   uart_tx_cfg #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
      .i_Clock         (i_Clock),
      .rst_n           (rst_n),
      .CLKS_PER_BIT    (CLKS_PER_BIT),
      .ld_CLKS_PER_BIT (ld_CLKS_PER_BIT),
      .i_Cfg_Data_Bits (i_Cfg_Data_Bits),
      .i_Cfg_Parity    (i_Cfg_Parity),
      .i_Cfg_Stop2     (i_Cfg_Stop2),
      .i_Tx_Valid      (i_Tx_Valid),
      .i_Tx_Data       (i_Tx_Data),
      .o_Tx_Ready      (o_Tx_Ready),
      .o_Tx_Serial     (o_Tx_Serial),
      .o_Tx_Active     (o_Tx_Active),
      .o_Tx_Done       (o_Tx_Done),
      .o_Fifo_Level    (o_Fifo_Level)
   );

   always #5 i_Clock = ~i_Clock;

   typedef struct {
      logic line;
      logic active;
      logic done;
   } cyc_t;

   cyc_t       exp_q[$];
   logic [8:0] words[$];
   int         lvl_q[$];
   logic       pend_done = 1'b0;
   int         vectors = 0;
   int         miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge i_Clock);
      #1;
   endtask

   task automatic load_div(input logic [DIV_W-1:0] v);
      CLKS_PER_BIT = v;
      ld_CLKS_PER_BIT = 1'b1;
      step();
      ld_CLKS_PER_BIT = 1'b0;
   endtask

   task automatic new_test();
      exp_q.delete();
      words.delete();
      lvl_q.delete();
      pend_done = 1'b0;
   endtask

   task automatic m_idle(input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{1'b1, 1'b0, pend_done});
         pend_done = 1'b0;
      end
   endtask

   // Reference frame: start, N data bits LSB first, optional parity, stop bits; each held div cycles.
   task automatic m_frame(input logic [8:0] d, input int nb_cfg, input int par, input logic s2, input int div);
      int n = (nb_cfg < 5) ? 5 : ((nb_cfg > 9) ? 9 : nb_cfg);
      int eff = (div == 0) ? 1 : div;
      int ones = 0;
      logic bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         bits.push_back(d[i]);
         ones += int'(d[i]);
      end
      if (par == 1) bits.push_back((ones % 2) == 1);
      if (par == 2) bits.push_back((ones % 2) == 0);
      if (par == 3) bits.push_back(1'b1);
      bits.push_back(1'b1);
      if (s2) bits.push_back(1'b1);
      foreach (bits[k])
         for (int c = 0; c < eff; c++) exp_q.push_back('{bits[k], 1'b1, 1'b0});
      pend_done = 1'b1;
   endtask

   task automatic run(input string tag, input int n_valid, input int ld_cycle, input logic [DIV_W-1:0] ld_val);
      for (int i = 0; i < exp_q.size(); i++) begin
         chk({tag, ".line"}, 32'(o_Tx_Serial), 32'(exp_q[i].line));
         chk({tag, ".active"}, 32'(o_Tx_Active), 32'(exp_q[i].active));
         chk({tag, ".done"}, 32'(o_Tx_Done), 32'(exp_q[i].done));
         if (i < lvl_q.size()) begin
            chk({tag, ".level"}, 32'(o_Fifo_Level), 32'(lvl_q[i]));
            chk({tag, ".ready"}, 32'(o_Tx_Ready), 32'(lvl_q[i] != DEPTH));
         end
         i_Tx_Valid = (i < n_valid);
         i_Tx_Data = (i < words.size()) ? words[i] : 9'h0;
         ld_CLKS_PER_BIT = (i == ld_cycle);
         if (i == ld_cycle) CLKS_PER_BIT = ld_val;
         step();
      end
      i_Tx_Valid = 1'b0;
      ld_CLKS_PER_BIT = 1'b0;
   endtask

   task automatic single(input string tag, input logic [8:0] d, input int nb, input int par,
                         input logic s2, input int div);
      new_test();
      i_Cfg_Data_Bits = 4'(nb);
      i_Cfg_Parity = 2'(par);
      i_Cfg_Stop2 = s2;
      words.push_back(d);
      lvl_q = '{0, 1, 0};
      m_idle(2);
      m_frame(d, nb, par, s2, div);
      m_idle(2);
      run(tag, 1, -1, '0);
   endtask

   initial begin
      int div_r;
      logic [8:0] w;

      repeat (2) step();
      chk("rst.line", 32'(o_Tx_Serial), 32'd1);
      chk("rst.ready", 32'(o_Tx_Ready), 32'd1);
      chk("rst.active", 32'(o_Tx_Active), 32'd0);
      chk("rst.done", 32'(o_Tx_Done), 32'd0);
      chk("rst.level", 32'(o_Fifo_Level), 32'd0);
      rst_n = 1'b1;
      step();

      load_div(4);
      single("basic_8n1", 9'h055, 8, 0, 1'b0, 4);
      load_div(2);
      single("7o1", 9'h003, 7, 2, 1'b0, 2);
      load_div(1);
      single("9e2", 9'h1FF, 9, 1, 1'b1, 1);
      load_div(0);
      single("div0", 9'h0B2, 6, 3, 1'b0, 0);

      for (int r = 0; r < 8; r++) begin
         div_r = int'($urandom_range(0, 4));
         load_div(DIV_W'(div_r));
         single("rand", 9'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                1'($urandom), div_r);
      end

      // Six cycles of Valid into a 4-deep FIFO with the first word popped at once.
      load_div(2);
      new_test();
      i_Cfg_Data_Bits = 4'd8;
      i_Cfg_Parity = 2'b00;
      i_Cfg_Stop2 = 1'b0;
      for (int i = 0; i < 6; i++) words.push_back(9'($urandom));
      lvl_q = '{0, 1, 1, 2, 3, 4};
      m_idle(2);
      for (int i = 0; i < 5; i++) begin
         m_frame(words[i], 8, 0, 1'b0, 2);
         m_idle(1);
      end
      m_idle(2);
      run("fill", 6, -1, '0);
      chk("fill.level_end", 32'(o_Fifo_Level), 32'd0);
      chk("fill.ready_end", 32'(o_Tx_Ready), 32'd1);

      load_div(3);
      new_test();
      words.push_back(9'h0A5);
      words.push_back(9'h13C);
      m_idle(2);
      m_frame(9'h0A5, 8, 0, 1'b0, 3);
      m_idle(1);
      m_frame(9'h13C, 8, 0, 1'b0, 5);
      m_idle(2);
      run("divchg", 2, 8, 5);

      // Reset lands on cycle 10, a zero data bit, with a second word still queued.
      load_div(2);
      new_test();
      words.push_back(9'h000);
      words.push_back(9'h0FF);
      m_idle(2);
      m_frame(9'h000, 8, 0, 1'b0, 2);
      while (exp_q.size() > 10) void'(exp_q.pop_back());
      run("pre_rst", 2, -1, '0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.line", 32'(o_Tx_Serial), 32'd1);
      chk("arst.level", 32'(o_Fifo_Level), 32'd0);
      chk("arst.active", 32'(o_Tx_Active), 32'd0);
      chk("arst.done", 32'(o_Tx_Done), 32'd0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         step();
         chk("post_rst.line", 32'(o_Tx_Serial), 32'd1);
         chk("post_rst.done", 32'(o_Tx_Done), 32'd0);
         chk("post_rst.level", 32'(o_Fifo_Level), 32'd0);
      end
      step();
      w = 9'($urandom);
      single("after_rst", w, 8, 1, 1'b1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
